// File: rtl/ps2_kbd_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_tx_if
//  Purpose  : Byte-queue / host-inhibit / PS/2 line bundle of ps2_kbd_tx.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_kbd_tx_if;
    logic [7:0] DIN;
    logic       DIN_WR;
    logic       INHIBIT;
    logic       FULL;
    logic       EMPTY;
    logic       BUSY;
    logic       OVERFLOW;
    logic       PS2CLK;
    logic       PS2DAT;

    modport master (
        output DIN, DIN_WR, INHIBIT,
        input  FULL, EMPTY, BUSY, OVERFLOW, PS2CLK, PS2DAT
    );

    modport slave (
        input  DIN, DIN_WR, INHIBIT,
        output FULL, EMPTY, BUSY, OVERFLOW, PS2CLK, PS2DAT
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_tx
//  Purpose  : PS/2 device-side transmitter: byte FIFO feeding an 11-bit frame
//             serialiser with host-inhibit abort and retransmit.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_kbd_tx #(
    parameter int CLK_DIV = 2500,
    parameter int GAP_CYC = 5000,
    parameter int FIFO_AW = 4
) (
    input  wire logic   CLK50M,
    input  wire logic   RESET,
    ps2_kbd_tx_if.slave kbd
);
    localparam int c_DEPTH   = 1 << FIFO_AW;
    localparam int c_CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DIV_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [FIFO_AW:0]   c_DEPTH_CNT = (FIFO_AW+1)'(c_DEPTH);
    localparam logic [FIFO_AW:0]   c_COUNT_ONE = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] c_PTR_ONE   = FIFO_AW'(1);
    localparam logic [3:0]         c_STOP_IDX  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BIT_HIGH = 2'd1,
        S_BIT_LOW  = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_idx;
    logic [10:0]        r_shift;
    logic [7:0]         r_hold;
    logic               r_retry;
    logic               r_ps2clk;
    logic               r_ps2dat;

    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_start;
    logic               w_pop;
    logic               w_abort;
    logic [7:0]         w_byte;

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);
    // FULL is judged on the pre-pop count, so a write in the same cycle as a pop is still dropped.
    assign w_wr    = kbd.DIN_WR && !w_full;
    assign w_start = (r_state == S_IDLE) && !kbd.INHIBIT && (!w_empty || r_retry);
    assign w_pop   = w_start && !r_retry;
    assign w_byte  = r_retry ? r_hold : r_mem[r_rd_ptr];
    assign w_abort = kbd.INHIBIT && (r_idx != c_STOP_IDX);

    assign kbd.FULL     = w_full;
    assign kbd.EMPTY    = w_empty;
    assign kbd.BUSY     = (r_state != S_IDLE);
    assign kbd.OVERFLOW = r_overflow;
    assign kbd.PS2CLK   = r_ps2clk;
    assign kbd.PS2DAT   = r_ps2dat;

    always_ff @(posedge CLK50M) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= kbd.DIN;
        end
    end

    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_COUNT_ONE;
                2'b01:   r_count <= r_count - c_COUNT_ONE;
                default: r_count <= r_count;
            endcase
            if (kbd.DIN_WR && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '1;
            r_hold   <= '0;
            r_retry  <= 1'b0;
            r_ps2clk <= 1'b1;
            r_ps2dat <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_shift  <= {1'b1, ~^w_byte, w_byte, 1'b0};
                        r_hold   <= w_byte;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_ps2clk <= 1'b1;
                        r_ps2dat <= 1'b0;
                        r_state  <= S_BIT_HIGH;
                    end
                end

                S_BIT_HIGH: begin
                    if (w_abort) begin
                        r_ps2clk <= 1'b1;
                        r_ps2dat <= 1'b1;
                        r_retry  <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == c_DIV_LAST) begin
                        r_cnt    <= '0;
                        r_ps2clk <= 1'b0;
                        r_state  <= S_BIT_LOW;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_BIT_LOW: begin
                    if (w_abort) begin
                        r_ps2clk <= 1'b1;
                        r_ps2dat <= 1'b1;
                        r_retry  <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == c_DIV_LAST) begin
                        r_cnt    <= '0;
                        r_ps2clk <= 1'b1;
                        if (r_idx == c_STOP_IDX) begin
                            r_ps2dat <= 1'b1;
                            r_retry  <= 1'b0;
                            r_state  <= S_GAP;
                        end else begin
                            // Next bit goes out on the same edge that raises the clock.
                            r_idx    <= r_idx + 4'd1;
                            r_shift  <= {1'b1, r_shift[10:1]};
                            r_ps2dat <= r_shift[1];
                            r_state  <= S_BIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_kbd_tx
//  Purpose  : Randomised scoreboard bench for ps2_kbd_tx with a PS/2 receiver.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_kbd_tx;
    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 8;
    localparam int FIFO_AW = 2;

    logic CLK50M = 1'b0;
    logic RESET  = 1'b0;
    bit   done   = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    logic [7:0] exp_q [$];

    ps2_kbd_tx_if bus ();

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .FIFO_AW(FIFO_AW)) dut (
        .CLK50M (CLK50M),
        .RESET  (RESET),
        .kbd    (bus)
    );

    always #5 CLK50M = ~CLK50M;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK50M);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input bit accept);
        bus.DIN    = b;
        bus.DIN_WR = 1'b1;
        if (accept) exp_q.push_back(b);
        tick();
        bus.DIN_WR = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!(bus.PS2DAT == 1'b0 && bus.PS2CLK == 1'b1) && n < 40) begin
            tick();
            n++;
        end
        checkn("start_timeout", n < 40 ? 1 : 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !bus.BUSY && bus.EMPTY) && n < 4000) begin
            tick();
            n++;
        end
        checkn("idle_timeout", n < 4000 ? 1 : 0, 1);
    endtask

    // receiver state
    int         m_nb, m_hrun, m_lrun, m_since, m_last_lrun;
    logic [10:0] m_bits;
    logic       m_pclk, m_pdat, m_last_stable;
    logic [7:0] m_data, m_exp;

    initial begin
        int busy_cnt, lows;
        bus.DIN = '0; bus.DIN_WR = 1'b0; bus.INHIBIT = 1'b0;
        #2 RESET = 1'b1;
        fork
            begin : stim
                repeat (3) tick();
                check1("rst_ps2clk", bus.PS2CLK, 1'b1);
                check1("rst_ps2dat", bus.PS2DAT, 1'b1);
                check1("rst_busy", bus.BUSY, 1'b0);
                check1("rst_full", bus.FULL, 1'b0);
                check1("rst_empty", bus.EMPTY, 1'b1);
                check1("rst_overflow", bus.OVERFLOW, 1'b0);
                RESET = 1'b0;
                repeat (2) tick();

                // single byte: latency and busy length
                wr(8'h1C, 1'b1);
                check1("pre_start_dat", bus.PS2DAT, 1'b1);
                tick();
                check1("start_latency", bus.PS2DAT, 1'b0);
                check1("busy_on", bus.BUSY, 1'b1);
                busy_cnt = 1;
                for (int i = 0; i < 300 && bus.BUSY; i++) begin
                    tick();
                    if (bus.BUSY) busy_cnt++;
                end
                checkn("busy_len", busy_cnt, 22 * CLK_DIV + GAP_CYC);
                wait_idle();

                // parity corner bytes
                wr(8'h00, 1'b1);
                wr(8'hFF, 1'b1);
                wr(8'h01, 1'b1);
                wait_idle();

                // FIFO full / overflow
                check1("ovf_before", bus.OVERFLOW, 1'b0);
                for (int i = 0; i < 4; i++) wr(8'($urandom), 1'b1);
                check1("full_after4", bus.FULL, 1'b0);
                wr(8'($urandom), 1'b1);
                check1("full_after5", bus.FULL, 1'b1);
                wr(8'hEE, 1'b0);
                check1("overflow_set", bus.OVERFLOW, 1'b1);
                check1("full_hold", bus.FULL, 1'b1);
                wait_idle();

                // inhibit abort during bit 4, retry, queued byte kept
                wr(8'hF0, 1'b1);
                wr(8'h5A, 1'b1);
                wait_start();
                repeat (36) tick();
                check1("inh_clk_low", bus.PS2CLK, 1'b0);
                bus.INHIBIT = 1'b1;
                tick();
                check1("abort_clk", bus.PS2CLK, 1'b1);
                check1("abort_dat", bus.PS2DAT, 1'b1);
                check1("abort_busy", bus.BUSY, 1'b0);
                lows = 0;
                for (int i = 0; i < 50; i++) begin
                    tick();
                    if (!bus.PS2CLK || !bus.PS2DAT) lows++;
                end
                checkn("inhibit_quiet", lows, 0);
                check1("retry_empty", bus.EMPTY, 1'b0);
                checkn("retry_pending", exp_q.size(), 2);
                bus.INHIBIT = 1'b0;
                wait_idle();

                // inhibit during stop bit does not abort; queued byte waits
                wr(8'h33, 1'b1);
                wr(8'h44, 1'b1);
                wait_start();
                repeat (84) tick();
                check1("stop_clk_low", bus.PS2CLK, 1'b0);
                bus.INHIBIT = 1'b1;
                repeat (40) tick();
                checkn("stop_frame_done", exp_q.size(), 1);
                check1("stop_busy", bus.BUSY, 1'b0);
                check1("stop_empty", bus.EMPTY, 1'b0);
                check1("stop_clk_idle", bus.PS2CLK, 1'b1);
                bus.INHIBIT = 1'b0;
                wait_idle();

                // randomised bursts with optional inhibit pulses
                for (int it = 0; it < 8; it++) begin
                    int n;
                    n = $urandom_range(1, 5);
                    for (int k = 0; k < n; k++) begin
                        wr(8'($urandom), 1'b1);
                        repeat ($urandom_range(0, 15)) tick();
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        repeat ($urandom_range(0, 90)) tick();
                        bus.INHIBIT = 1'b1;
                        repeat (30) tick();
                        bus.INHIBIT = 1'b0;
                    end
                    wait_idle();
                end

                // async reset mid-frame during bit 6
                check1("ovf_sticky", bus.OVERFLOW, 1'b1);
                wr(8'hA5, 1'b1);
                wr(8'h3C, 1'b1);
                wait_start();
                repeat (52) tick();
                check1("rst_mid_clk_low", bus.PS2CLK, 1'b0);
                RESET = 1'b1;
                #1;
                check1("arst_clk", bus.PS2CLK, 1'b1);
                check1("arst_dat", bus.PS2DAT, 1'b1);
                check1("arst_empty", bus.EMPTY, 1'b1);
                check1("arst_overflow", bus.OVERFLOW, 1'b0);
                check1("arst_busy", bus.BUSY, 1'b0);
                exp_q.delete();
                repeat (3) tick();
                RESET = 1'b0;
                lows = 0;
                for (int i = 0; i < 200; i++) begin
                    tick();
                    if (!bus.PS2CLK || !bus.PS2DAT || bus.BUSY) lows++;
                end
                checkn("post_reset_quiet", lows, 0);
                done = 1'b1;
            end

            begin : mon
                m_nb = 0; m_hrun = 0; m_lrun = 0; m_since = 0; m_last_lrun = CLK_DIV;
                m_pclk = 1'b1; m_pdat = 1'b1; m_last_stable = 1'b1; m_bits = '1;
                while (!done) begin
                    @(negedge CLK50M);
                    if (RESET) begin
                        m_nb = 0; m_hrun = 0; m_lrun = 0;
                        m_pclk = 1'b1; m_pdat = 1'b1;
                        continue;
                    end
                    m_since++;
                    if (m_pclk && !bus.PS2CLK) begin
                        // a long high stretch mid-frame means the host aborted it
                        if (m_nb > 0 && m_hrun > 2 * CLK_DIV) m_nb = 0;
                        if (m_nb > 0) begin
                            checkn("bit_period", m_since, 2 * CLK_DIV);
                            checkn("clk_low_len", m_last_lrun, CLK_DIV);
                            check1("dat_stable", m_last_stable, 1'b1);
                        end
                        m_bits[m_nb] = bus.PS2DAT;
                        m_nb++;
                        m_since = 0;
                        if (m_nb == 11) begin
                            m_data = m_bits[8:1];
                            check1("start_bit", m_bits[0], 1'b0);
                            check1("stop_bit", m_bits[10], 1'b1);
                            checkn("parity_odd", $countones({m_bits[9], m_data}) % 2, 1);
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_frame: got %02h expected none", m_data);
                            end else begin
                                m_exp = exp_q.pop_front();
                                checkn("rx_byte", int'(m_data), int'(m_exp));
                            end
                            m_nb = 0;
                        end
                    end
                    if (!m_pclk && bus.PS2CLK) begin
                        m_last_lrun   = m_lrun;
                        m_last_stable = (m_nb > 0) ? (m_pdat == m_bits[m_nb-1]) : 1'b1;
                    end
                    if (bus.PS2CLK) begin
                        m_hrun++;
                        m_lrun = 0;
                    end else begin
                        m_lrun++;
                        m_hrun = 0;
                    end
                    m_pclk = bus.PS2CLK;
                    m_pdat = bus.PS2DAT;
                end
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
